jesd204_rx_cgs_multi: RTL and testbench

//  Multi-lane JESD204 RX code group synchronisation monitor. Runs one CGS state

---
 rtl/jesd204_rx_cgs_multi_if.sv | 50 +++++
 rtl/jesd204_rx_cgs_multi.sv | 182 ++++++++++++++++++
 tb/tb_jesd204_rx_cgs_multi.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jesd204_rx_cgs_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : jesd204_rx_cgs_multi_if
//  Purpose  : Bundles the configuration, per-character decoder flags and
//             status outputs of the multi-lane CGS monitor.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    cfg_lanes_disable  [NUM_LANES]                  1 = lane masked
//    cfg_err_threshold  [ERR_CNT_WIDTH]              CHECK->INIT error count
//    char_is_cgs        [NUM_LANES*DATA_PATH_WIDTH]  char is /K/, lane-major
//    char_is_error      [NUM_LANES*DATA_PATH_WIDTH]  char decode error
//    status_los_clear   [1]                          clear all LOS counters
//    lane_ready         [NUM_LANES]                  per-lane CGS complete
//    all_ready          [1]                          all enabled lanes ready
//    status_state       [2*NUM_LANES]                per-lane state
//    status_los_count   [NUM_LANES*LOS_CNT_WIDTH]    per-lane LOS count
//  Modports
//    master : drives config and decoder flags, observes status
//    slave  : the monitor itself
// ============================================================================
interface jesd204_rx_cgs_multi_if #(
    parameter int NUM_LANES       = 4,
    parameter int DATA_PATH_WIDTH = 4,
    parameter int ERR_CNT_WIDTH   = 2,
    parameter int LOS_CNT_WIDTH   = 8
);
    logic [NUM_LANES-1:0]                 cfg_lanes_disable;
    logic [ERR_CNT_WIDTH-1:0]             cfg_err_threshold;
    logic [NUM_LANES*DATA_PATH_WIDTH-1:0] char_is_cgs;
    logic [NUM_LANES*DATA_PATH_WIDTH-1:0] char_is_error;
    logic                                 status_los_clear;
    logic [NUM_LANES-1:0]                 lane_ready;
    logic                                 all_ready;
    logic [2*NUM_LANES-1:0]               status_state;
    logic [NUM_LANES*LOS_CNT_WIDTH-1:0]   status_los_count;

    modport master (
        output cfg_lanes_disable, cfg_err_threshold, char_is_cgs,
               char_is_error, status_los_clear,
        input  lane_ready, all_ready, status_state, status_los_count
    );

    modport slave (
        input  cfg_lanes_disable, cfg_err_threshold, char_is_cgs,
               char_is_error, status_los_clear,
        output lane_ready, all_ready, status_state, status_los_count
    );
endinterface
`default_nettype wire

// File: rtl/jesd204_rx_cgs_multi.sv
`default_nettype none
// ============================================================================
//  Module   : jesd204_rx_cgs_multi
//  Purpose  : Multi-lane JESD204 RX code group synchronisation monitor. One
//             CGS state machine per lane (INIT/CHECK/DATA) driven by the
//             per-character /K/ and error flags of the 8b10b decoders, with a
//             runtime error threshold, minimum CGS run length, lane masking,
//             an aggregated all-lanes-ready flag and per-lane LOS counters.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk     in   core clock
//    resetn  in   asynchronous reset, active low
//    bus     slave modport of jesd204_rx_cgs_multi_if (config, decoder
//            flags in; lane_ready/all_ready/status_state/status_los_count out)
// ============================================================================
module jesd204_rx_cgs_multi #(
    parameter int NUM_LANES       = 4,
    parameter int DATA_PATH_WIDTH = 4,
    parameter int ERR_CNT_WIDTH   = 2,
    parameter int CGS_MIN_BEATS   = 1,
    parameter int LOS_CNT_WIDTH   = 8
) (
    input wire clk,
    input wire resetn,
    jesd204_rx_cgs_multi_if.slave bus
);

    // CGS_MIN_BEATS is at most 255, so an 8-bit run counter always reaches
    // the exit condition before it could wrap.
    localparam int RUN_WIDTH = 8;
    localparam logic [RUN_WIDTH:0]       MIN_BEATS_EXT = (RUN_WIDTH+1)'(CGS_MIN_BEATS);
    localparam logic [RUN_WIDTH:0]       RUN_ONE_EXT   = (RUN_WIDTH+1)'(1);
    localparam logic [RUN_WIDTH-1:0]     RUN_ONE       = RUN_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE       = ERR_CNT_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX       = '1;
    localparam logic [LOS_CNT_WIDTH-1:0] LOS_ONE       = LOS_CNT_WIDTH'(1);
    localparam logic [LOS_CNT_WIDTH-1:0] LOS_MAX       = '1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_CHECK = 2'b01,
        ST_DATA  = 2'b10
    } state_e;

    logic [NUM_LANES-1:0] w_lane_ready;
    logic                 all_ready_q;
    logic                 all_ready_d;

    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            logic [DATA_PATH_WIDTH-1:0] w_cgs_chars;
            logic [DATA_PATH_WIDTH-1:0] w_err_chars;
            logic                       w_cgs;
            logic                       w_err;
            logic                       w_all_err;
            logic                       w_disabled;

            state_e                     state_q,   state_d;
            logic [RUN_WIDTH-1:0]       cgs_run_q, cgs_run_d;
            logic [ERR_CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
            logic                       ready_q,   ready_d;
            logic [LOS_CNT_WIDTH-1:0]   los_q,     los_d;
            logic                       los_event;

            assign w_cgs_chars = bus.char_is_cgs[l*DATA_PATH_WIDTH +: DATA_PATH_WIDTH];
            assign w_err_chars = bus.char_is_error[l*DATA_PATH_WIDTH +: DATA_PATH_WIDTH];
            assign w_cgs       = &w_cgs_chars;
            assign w_err       = |w_err_chars;
            assign w_all_err   = &w_err_chars;
            assign w_disabled  = bus.cfg_lanes_disable[l];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    state_q   <= ST_INIT;
                    cgs_run_q <= '0;
                    err_cnt_q <= '0;
                    ready_q   <= 1'b0;
                    los_q     <= '0;
                end else begin
                    state_q   <= state_d;
                    cgs_run_q <= cgs_run_d;
                    err_cnt_q <= err_cnt_d;
                    ready_q   <= ready_d;
                    los_q     <= los_d;
                end
            end

            always_comb begin
                state_d   = state_q;
                cgs_run_d = '0;
                err_cnt_d = '0;
                ready_d   = ready_q;
                los_event = 1'b0;
                los_d     = los_q;

                case (state_q)
                    ST_CHECK: begin
                        // '>=' rather than '==' so a threshold of zero drops
                        // on any error beat even though entering CHECK from
                        // DATA already counted one error.
                        if (!w_err) begin
                            state_d = ST_DATA;
                        end else if (w_all_err || (err_cnt_q >= bus.cfg_err_threshold)) begin
                            state_d = ST_INIT;
                        end
                    end
                    ST_DATA: begin
                        if (w_err) begin
                            state_d = ST_CHECK;
                        end
                    end
                    default: begin
                        // INIT, and the unreachable 2'b11 encoding
                        state_d = ST_INIT;
                        if (w_cgs) begin
                            if (({1'b0, cgs_run_q} + RUN_ONE_EXT) >= MIN_BEATS_EXT) begin
                                state_d = ST_CHECK;
                            end else begin
                                cgs_run_d = cgs_run_q + RUN_ONE;
                            end
                        end
                    end
                endcase

                if ((state_q == ST_CHECK) || (state_q == ST_DATA)) begin
                    if (w_err) begin
                        err_cnt_d = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_ONE;
                    end
                end
                if (state_d == ST_INIT) begin
                    err_cnt_d = '0;
                end

                // lane_ready holds through CHECK so brief error bursts in
                // DATA do not glitch the ready flag.
                case (state_q)
                    ST_DATA:  ready_d = 1'b1;
                    ST_CHECK: ready_d = ready_q;
                    default:  ready_d = 1'b0;
                endcase

                los_event = (state_q == ST_CHECK) && (state_d == ST_INIT) && ready_q;

                if (w_disabled) begin
                    state_d   = ST_INIT;
                    cgs_run_d = '0;
                    err_cnt_d = '0;
                    ready_d   = 1'b0;
                    los_event = 1'b0;
                end

                if (bus.status_los_clear) begin
                    los_d = '0;
                end else if (los_event && (los_q != LOS_MAX)) begin
                    los_d = los_q + LOS_ONE;
                end
            end

            assign w_lane_ready[l]                                       = ready_q;
            assign bus.status_state[2*l +: 2]                            = state_q;
            assign bus.status_los_count[l*LOS_CNT_WIDTH +: LOS_CNT_WIDTH] = los_q;
        end
    endgenerate

    // Masked lanes count as ready; with every lane masked the output stays low.
    assign all_ready_d = (|(~bus.cfg_lanes_disable)) &&
                         (&(w_lane_ready | bus.cfg_lanes_disable));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            all_ready_q <= 1'b0;
        end else begin
            all_ready_q <= all_ready_d;
        end
    end

    assign bus.lane_ready = w_lane_ready;
    assign bus.all_ready  = all_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_jesd204_rx_cgs_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jesd204_rx_cgs_multi
//  Purpose  : Directed scoreboard bench for jesd204_rx_cgs_multi. Expected
//             status values are queued with the cycle they become due when
//             stimulus is applied, and compared once that cycle is reached.
//             A second instance runs with a minimum CGS run of four beats.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jesd204_rx_cgs_multi;

    localparam int NL  = 4;
    localparam int DPW = 4;
    localparam int ECW = 2;
    localparam int LW  = 8;

    localparam int F_RDY = 0;
    localparam int F_ALL = 1;
    localparam int F_ST  = 2;
    localparam int F_LOS = 3;

    typedef struct {
        string       tag;
        int          dut;
        int          fld;
        int          lane;
        logic [31:0] exp;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    jesd204_rx_cgs_multi_if #(.NUM_LANES(NL), .DATA_PATH_WIDTH(DPW),
                              .ERR_CNT_WIDTH(ECW), .LOS_CNT_WIDTH(LW)) bus0 ();
    jesd204_rx_cgs_multi_if #(.NUM_LANES(NL), .DATA_PATH_WIDTH(DPW),
                              .ERR_CNT_WIDTH(ECW), .LOS_CNT_WIDTH(LW)) bus1 ();

    jesd204_rx_cgs_multi #(.NUM_LANES(NL), .DATA_PATH_WIDTH(DPW), .ERR_CNT_WIDTH(ECW),
                           .CGS_MIN_BEATS(1), .LOS_CNT_WIDTH(LW)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    jesd204_rx_cgs_multi #(.NUM_LANES(NL), .DATA_PATH_WIDTH(DPW), .ERR_CNT_WIDTH(ECW),
                           .CGS_MIN_BEATS(4), .LOS_CNT_WIDTH(LW)) dut4 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1)
    );

    function automatic logic [31:0] observe(int dut, int fld, int lane);
        logic [31:0] r;
        r = '0;
        if (dut == 0) begin
            case (fld)
                F_RDY:   r[NL-1:0]   = bus0.lane_ready;
                F_ALL:   r[0]        = bus0.all_ready;
                F_ST:    r[2*NL-1:0] = bus0.status_state;
                default: r[LW-1:0]   = bus0.status_los_count[lane*LW +: LW];
            endcase
        end else begin
            case (fld)
                F_RDY:   r[NL-1:0]   = bus1.lane_ready;
                F_ALL:   r[0]        = bus1.all_ready;
                F_ST:    r[2*NL-1:0] = bus1.status_state;
                default: r[LW-1:0]   = bus1.status_los_count[lane*LW +: LW];
            endcase
        end
        return r;
    endfunction

    task automatic exp_at(string tag, int dut, int fld, int lane, logic [31:0] val, int dly);
        exp_t e;
        e.tag  = tag;
        e.dut  = dut;
        e.fld  = fld;
        e.lane = lane;
        e.exp  = val;
        e.due  = cyc + dly;
        sb.push_back(e);
    endtask

    task automatic check_due();
        exp_t        keep[$];
        logic [31:0] obs;
        foreach (sb[i]) begin
            if (sb[i].due <= cyc) begin
                obs = observe(sb[i].dut, sb[i].fld, sb[i].lane);
                n_checks++;
                assert (obs === sb[i].exp) else begin
                    n_errors++;
                    $error("FAIL %s: observed=0x%0h expected=0x%0h cycle=%0d",
                           sb[i].tag, obs, sb[i].exp, cyc);
                end
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    task automatic drive(int dut, int lane, logic [DPW-1:0] cgs, logic [DPW-1:0] err);
        if (dut == 0) begin
            bus0.char_is_cgs[lane*DPW +: DPW]   = cgs;
            bus0.char_is_error[lane*DPW +: DPW] = err;
        end else begin
            bus1.char_is_cgs[lane*DPW +: DPW]   = cgs;
            bus1.char_is_error[lane*DPW +: DPW] = err;
        end
    endtask

    task automatic drive_all(int dut, logic [DPW-1:0] cgs, logic [DPW-1:0] err);
        for (int l = 0; l < NL; l++) drive(dut, l, cgs, err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] want;

        resetn                 = 1'b0;
        bus0.cfg_lanes_disable = '0;
        bus0.cfg_err_threshold = 2'd3;
        bus0.status_los_clear  = 1'b0;
        bus0.char_is_cgs       = '0;
        bus0.char_is_error     = '0;
        bus1.cfg_lanes_disable = '0;
        bus1.cfg_err_threshold = 2'd3;
        bus1.status_los_clear  = 1'b0;
        bus1.char_is_cgs       = '0;
        bus1.char_is_error     = '0;

        // Reset state
        #12;
        exp_at("rst_ready", 0, F_RDY, 0, 32'h0, 0);
        exp_at("rst_all",   0, F_ALL, 0, 32'h0, 0);
        exp_at("rst_state", 0, F_ST,  0, 32'h0, 0);
        for (int l = 0; l < NL; l++) exp_at("rst_los", 0, F_LOS, l, 32'h0, 0);
        check_due();
        tick();
        resetn = 1'b1;
        tick();

        // One /K/ beat on every lane, then clean data
        drive_all(0, 4'hF, 4'h0);
        exp_at("s1_state_check", 0, F_ST,  0, 32'h55, 1);
        exp_at("s1_state_data",  0, F_ST,  0, 32'hAA, 2);
        exp_at("s1_ready_early", 0, F_RDY, 0, 32'h0,  2);
        exp_at("s1_ready",       0, F_RDY, 0, 32'hF,  3);
        exp_at("s1_all_early",   0, F_ALL, 0, 32'h0,  3);
        exp_at("s1_all",         0, F_ALL, 0, 32'h1,  4);
        tick();
        drive_all(0, 4'h0, 4'h0);
        repeat (4) tick();

        // Lane 1: four single-char error beats, threshold 3
        drive(0, 1, 4'h0, 4'b0001);
        exp_at("s2_state_check", 0, F_ST,  0, 32'hA6, 1);
        exp_at("s2_state_hold",  0, F_ST,  0, 32'hA6, 3);
        exp_at("s2_state_init",  0, F_ST,  0, 32'hA2, 4);
        exp_at("s2_los1",        0, F_LOS, 1, 32'h1,  4);
        exp_at("s2_los0",        0, F_LOS, 0, 32'h0,  4);
        exp_at("s2_ready_hold",  0, F_RDY, 0, 32'hF,  4);
        exp_at("s2_ready_drop",  0, F_RDY, 0, 32'hD,  5);
        exp_at("s2_all_hold",    0, F_ALL, 0, 32'h1,  5);
        exp_at("s2_all_drop",    0, F_ALL, 0, 32'h0,  6);
        repeat (4) tick();
        drive(0, 1, 4'h0, 4'h0);
        repeat (3) tick();

        // Lane 2: two all-error beats -> CHECK then INIT with LOS
        drive(0, 2, 4'h0, 4'hF);
        exp_at("s3_state_check", 0, F_ST,  0, 32'h92, 1);
        exp_at("s3_state_init",  0, F_ST,  0, 32'h82, 2);
        exp_at("s3_los2",        0, F_LOS, 2, 32'h1,  2);
        exp_at("s3_los1",        0, F_LOS, 1, 32'h1,  2);
        exp_at("s3_ready_hold",  0, F_RDY, 0, 32'hD,  2);
        exp_at("s3_ready_drop",  0, F_RDY, 0, 32'h9,  3);
        repeat (2) tick();
        drive(0, 2, 4'h0, 4'h0);
        tick();
        // resync lane 2
        drive(0, 2, 4'hF, 4'h0);
        exp_at("s3_resync_check", 0, F_ST,  0, 32'h92, 1);
        exp_at("s3_resync_data",  0, F_ST,  0, 32'hA2, 2);
        exp_at("s3_resync_ready", 0, F_RDY, 0, 32'hD,  3);
        tick();
        drive(0, 2, 4'h0, 4'h0);
        repeat (2) tick();
        // single error beat then clean: back to DATA, no LOS
        drive(0, 2, 4'h0, 4'b0001);
        exp_at("s3_single_check", 0, F_ST,  0, 32'h92, 1);
        exp_at("s3_single_data",  0, F_ST,  0, 32'hA2, 2);
        exp_at("s3_single_los",   0, F_LOS, 2, 32'h1,  2);
        exp_at("s3_single_ready", 0, F_RDY, 0, 32'hD,  2);
        tick();
        drive(0, 2, 4'h0, 4'h0);
        repeat (2) tick();

        // Minimum run of four /K/ beats (second instance)
        drive_all(1, 4'hF, 4'h0);
        exp_at("s4_run1",      1, F_ST, 0, 32'h00, 1);
        exp_at("s4_run2",      1, F_ST, 0, 32'h00, 2);
        exp_at("s4_run3",      1, F_ST, 0, 32'h00, 3);
        exp_at("s4_run_break", 1, F_ST, 0, 32'h00, 4);
        repeat (3) tick();
        drive_all(1, 4'h0, 4'h0);
        tick();
        bus1.cfg_lanes_disable = 4'b0100;
        drive(1, 0, 4'hF, 4'h0);
        drive(1, 1, 4'hF, 4'h0);
        drive(1, 3, 4'hF, 4'h0);
        exp_at("s4_min_minus1", 1, F_ST,  0, 32'h00, 3);
        exp_at("s4_min_check",  1, F_ST,  0, 32'h45, 4);
        exp_at("s4_data",       1, F_ST,  0, 32'h8A, 5);
        exp_at("s4_ready",      1, F_RDY, 0, 32'hB,  6);
        exp_at("s4_all_early",  1, F_ALL, 0, 32'h0,  6);
        exp_at("s4_all_masked", 1, F_ALL, 0, 32'h1,  7);
        repeat (4) tick();
        drive_all(1, 4'h0, 4'h0);
        repeat (3) tick();

        // Threshold 0 and LOS saturation on lane 0, then clear on a LOS beat
        bus0.cfg_err_threshold = 2'd0;
        for (int ev = 1; ev <= 257; ev++) begin
            if (ev == 1) begin
                exp_at("thr0_check", 0, F_ST, 0, 32'hA1, 1);
                exp_at("thr0_init",  0, F_ST, 0, 32'hA0, 2);
            end
            drive(0, 0, 4'h0, 4'b0001);
            tick();
            if (ev == 257) begin
                bus0.status_los_clear = 1'b1;
                exp_at("s5_clear_los0", 0, F_LOS, 0, 32'h0, 1);
                exp_at("s5_clear_los1", 0, F_LOS, 1, 32'h0, 1);
                exp_at("s5_clear_los2", 0, F_LOS, 2, 32'h0, 1);
            end else if (ev == 1 || ev == 2 || ev == 128 || ev == 255 || ev == 256) begin
                want = (ev > 255) ? 32'hFF : 32'(ev);
                exp_at("s5_los0_count", 0, F_LOS, 0, want, 1);
            end
            tick();
            bus0.status_los_clear = 1'b0;
            drive(0, 0, 4'hF, 4'h0);
            tick();
            drive(0, 0, 4'h0, 4'h0);
            repeat (2) tick();
        end
        bus0.cfg_err_threshold = 2'd3;

        // Mask lane 3, then unmask: it must restart from INIT
        bus0.cfg_lanes_disable = 4'b1000;
        exp_at("dis_state", 0, F_ST,  0, 32'h22, 1);
        exp_at("dis_ready", 0, F_RDY, 0, 32'h5,  1);
        tick();
        bus0.cfg_lanes_disable = 4'b0000;
        exp_at("reen_state", 0, F_ST,  0, 32'h22, 1);
        exp_at("reen_ready", 0, F_RDY, 0, 32'h5,  1);
        tick();

        // Bring everything to DATA, then async reset between edges
        drive_all(0, 4'hF, 4'h0);
        exp_at("s6_pre_state", 0, F_ST,  0, 32'hAA, 2);
        exp_at("s6_pre_ready", 0, F_RDY, 0, 32'hF,  3);
        exp_at("s6_pre_all",   0, F_ALL, 0, 32'h1,  4);
        tick();
        drive_all(0, 4'h0, 4'h0);
        repeat (4) tick();
        #2;
        resetn = 1'b0;
        #1;
        exp_at("s6_rst_ready", 0, F_RDY, 0, 32'h0, 0);
        exp_at("s6_rst_all",   0, F_ALL, 0, 32'h0, 0);
        exp_at("s6_rst_state", 0, F_ST,  0, 32'h0, 0);
        check_due();
        tick();
        resetn = 1'b1;
        drive_all(0, 4'hF, 4'h0);
        exp_at("s6_resync_check", 0, F_ST,  0, 32'h55, 1);
        exp_at("s6_resync_data",  0, F_ST,  0, 32'hAA, 2);
        exp_at("s6_resync_ready", 0, F_RDY, 0, 32'hF,  3);
        exp_at("s6_resync_all",   0, F_ALL, 0, 32'h1,  4);
        tick();
        drive_all(0, 4'h0, 4'h0);
        repeat (5) tick();

        n_checks++;
        assert (sb.size() == 0) else begin
            n_errors++;
            $error("FAIL scoreboard_drain: observed=%0d pending expected=0 pending", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
